ram_sp_clr: RTL

Parametrised single-port synchronous RAM with a registered read port, a read-valid strobe and a hardware clear engine that walks every word after reset or on request. It replaces the fixed 32x8 scratch RAM in datapath blocks that need configurable width and depth. It also needs a real initialisation, because an asynchronous reset cannot clear an array.

---
 rtl/ram_sp_clr.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - single-port synchronous RAM with registered read and hardware clear engine
//
// Optional feature macro: RAM_PARITY_EN (per-word even parity, par_inj/par_err ports).
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-low reset
//   en        access enable
//   wr_rd     1 = write, 0 = read (with en=1)
//   clr       start a full-array clear (honoured in IDLE only)
//   addr      word address
//   data_in   write data
//   par_inj   invert stored parity on this write (RAM_PARITY_EN only)
//   data_out  registered read data, holds last read value
//   rd_valid  one-cycle pulse when data_out was updated
//   busy      clear engine active, accesses ignored
//   par_err   parity mismatch on the read shown with rd_valid (RAM_PARITY_EN only)

module ram_sp_clr #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_rd,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef RAM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // An access is honoured only in IDLE and only when no clear is requested
  // in the same cycle: clr wins and the access is dropped.
  assign acc_ok = (state == S_IDLE) && !clr && en;

  // Write port shared by the clear engine and user writes. Gated by rst so
  // that holding reset never disturbs array contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    if (rst) begin
      if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = INIT_VAL;
      end else if (acc_ok && wr_rd) begin
        mem_we = 1'b1;
      end
    end
  end

  // The array has no reset: an asynchronous reset cannot clear it, which is
  // why the clear engine exists.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_wbit;

  always_comb begin
    par_wbit = ^data_in ^ par_inj;
    if (state == S_CLEAR) begin
      par_wbit = ^INIT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_waddr] <= par_wbit;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_CLEAR;
      clr_ptr  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b1;
`ifdef RAM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err  <= 1'b0;
`endif
      case (state)
        S_CLEAR: begin
          // clr_ptr wraps back to 0 on the final word.
          clr_ptr <= clr_ptr + PTR_ONE;
          if (clr_ptr == PTR_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end else if (en && !wr_rd) begin
            data_out <= mem[addr];
            rd_valid <= 1'b1;
`ifdef RAM_PARITY_EN
            par_err  <= (^mem[addr]) ^ par_mem[addr];
`endif
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule
